mesh_router_node: RTL

Single mesh router node, the next generation of the 4-terminal bus/mesh DUT. It has five ports: N, S, W, E and Local.
- Input side: pops packets directly from upstream FIFO heads (pndng/pop handshake).
- Routing: dimension-ordered (XY or YX, selectable), plus broadcast replication; out-of-mesh destinations are dropped and counted.
- Output side: each port has its own output FIFO, drained by downstream pop.
One node sits at every (id_r, id_c) grid point; Local connects to the terminal.

---
 rtl/mesh_pkg.sv | 57 +++++
 rtl/mesh_out_fifo.sv | 58 +++++
 rtl/mesh_router_node.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mesh_pkg.sv
// Shared port indices and header helpers for the mesh router node:
// dimension-ordered routing, broadcast detection and round-robin selection.
package mesh_pkg;

  localparam int num_ntrfs = 5;

  localparam logic [2:0] P_N = 3'd0;
  localparam logic [2:0] P_S = 3'd1;
  localparam logic [2:0] P_W = 3'd2;
  localparam logic [2:0] P_E = 3'd3;
  localparam logic [2:0] P_L = 3'd4;

  // mode 0 resolves the column first (XY), mode 1 the row first (YX)
  function automatic logic [2:0] route(input logic [31:0] dest_r, input logic [31:0] dest_c,
                                       input logic [31:0] id_r, input logic [31:0] id_c,
                                       input logic mode);
    logic [2:0] port;
    port = P_L;
    if (mode == 1'b0) begin
      if (dest_c > id_c)      port = P_E;
      else if (dest_c < id_c) port = P_W;
      else if (dest_r > id_r) port = P_S;
      else if (dest_r < id_r) port = P_N;
      else                    port = P_L;
    end else begin
      if (dest_r > id_r)      port = P_S;
      else if (dest_r < id_r) port = P_N;
      else if (dest_c > id_c) port = P_E;
      else if (dest_c < id_c) port = P_W;
      else                    port = P_L;
    end
    return port;
  endfunction

  function automatic logic is_bcast(input logic [31:0] dest_r, input logic [31:0] dest_c,
                                    input logic [31:0] row_w, input logic [31:0] col_w);
    return (dest_r == ((32'd1 << row_w) - 32'd1)) && (dest_c == ((32'd1 << col_w) - 32'd1));
  endfunction

  // first requester at or after ptr; result is {found, index}
  function automatic logic [3:0] rr_pick(input logic [num_ntrfs-1:0] req, input logic [2:0] ptr);
    logic [3:0] res;
    int j;
    res = 4'd0;
    for (int k = num_ntrfs - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % num_ntrfs;
      if (req[j]) res = {1'b1, 3'(j)};
      else        res = res;
    end
    return res;
  endfunction

  function automatic logic [2:0] next_ptr(input logic [2:0] p);
    return (p == 3'(num_ntrfs - 1)) ? 3'd0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/mesh_out_fifo.sv
// Per-port output FIFO; push is refused when full and a pop on empty is ignored.
module mesh_out_fifo #(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4
) (
  input  logic               clk_i,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [pckg_sz-1:0] din,
  output logic [pckg_sz-1:0] dout,
  output logic               full,
  output logic               empty
);

  localparam int ptr_w = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int cnt_w = $clog2(fifo_depth + 1);

  logic [pckg_sz-1:0] mem_r [fifo_depth];
  logic [ptr_w-1:0]   wr_r;
  logic [ptr_w-1:0]   rd_r;
  logic [cnt_w-1:0]   cnt_r;
  logic               do_push_s;
  logic               do_pop_s;

  assign full      = (cnt_r == cnt_w'(fifo_depth));
  assign empty     = (cnt_r == '0);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  // an empty FIFO presents zero rather than a stale entry
  assign dout      = empty ? '0 : mem_r[rd_r];

  // storage write
  always_ff @(posedge clk_i) begin
    if (do_push_s) mem_r[wr_r] <= din;
    else           mem_r[wr_r] <= mem_r[wr_r];
  end

  // pointers wrap at fifo_depth, which need not be a power of two
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      wr_r  <= '0;
      rd_r  <= '0;
      cnt_r <= '0;
    end else begin
      if (do_push_s) wr_r <= (wr_r == ptr_w'(fifo_depth - 1)) ? '0 : wr_r + ptr_w'(1);
      else           wr_r <= wr_r;
      if (do_pop_s)  rd_r <= (rd_r == ptr_w'(fifo_depth - 1)) ? '0 : rd_r + ptr_w'(1);
      else           rd_r <= rd_r;
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + cnt_w'(1);
        2'b01:   cnt_r <= cnt_r - cnt_w'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/mesh_router_node.sv
// Five-port mesh router node: dimension-ordered unicast with per-output
// round-robin arbitration, broadcast replication and out-of-mesh drop counting.
module mesh_router_node
  import mesh_pkg::*;
#(
  parameter int pckg_sz    = 40,
  parameter int row_w      = 4,
  parameter int col_w      = 4,
  parameter int fifo_depth = 4,
  parameter int id_r       = 0,
  parameter int id_c       = 0,
  parameter int rows       = 4,
  parameter int columns    = 4,
  parameter int route_mode = 0
) (
  input  logic                 clk_i,
  input  logic                 reset,
  input  logic [pckg_sz-1:0]   data_out_i_in [num_ntrfs-1:0],
  input  logic [num_ntrfs-1:0] pndng_i_in,
  output logic [num_ntrfs-1:0] popin,
  output logic [pckg_sz-1:0]   data_out [num_ntrfs-1:0],
  output logic [num_ntrfs-1:0] pndng,
  input  logic [num_ntrfs-1:0] pop,
  output logic [15:0]          drop_cnt
);

  localparam logic [31:0] rows_u    = 32'(rows);
  localparam logic [31:0] columns_u = 32'(columns);

  logic [row_w-1:0]     dr_s   [num_ntrfs];
  logic [col_w-1:0]     dc_s   [num_ntrfs];
  logic [2:0]           tgt_s  [num_ntrfs];
  logic [num_ntrfs-1:0] bc_s;
  logic [num_ntrfs-1:0] drop_s;
  logic [num_ntrfs-1:0] uni_s;
  logic                 bc_cycle_s;
  logic [num_ntrfs-1:0] req_s  [num_ntrfs];
  logic [3:0]           pick_s [num_ntrfs];
  logic [num_ntrfs-1:0] ugnt_s;
  logic [3:0]           bpick_s;
  logic                 bc_ok_s;
  logic                 bc_go_s;
  logic [num_ntrfs-1:0] popin_s;
  logic [num_ntrfs-1:0] push_s;
  logic [pckg_sz-1:0]   din_s  [num_ntrfs];
  logic [num_ntrfs-1:0] full_s;
  logic [num_ntrfs-1:0] empty_s;
  logic [2:0]           rr_r   [num_ntrfs];
  logic [2:0]           bptr_r;
  logic [15:0]          drop_cnt_r;
  logic [2:0]           drop_sum_s;
  logic [16:0]          drop_add_s;

  // header decode and classification of every pending head
  always_comb begin
    for (int i = 0; i < num_ntrfs; i++) begin
      dr_s[i]   = data_out_i_in[i][pckg_sz-1 -: row_w];
      dc_s[i]   = data_out_i_in[i][pckg_sz-row_w-1 -: col_w];
      bc_s[i]   = pndng_i_in[i] && is_bcast(32'(dr_s[i]), 32'(dc_s[i]), 32'(row_w), 32'(col_w));
      drop_s[i] = pndng_i_in[i] && !bc_s[i] &&
                  ((32'(dr_s[i]) >= rows_u) || (32'(dc_s[i]) >= columns_u));
      uni_s[i]  = pndng_i_in[i] && !bc_s[i] && !drop_s[i];
      tgt_s[i]  = route(32'(dr_s[i]), 32'(dc_s[i]), 32'(id_r), 32'(id_c), route_mode != 0);
    end
  end

  assign bc_cycle_s = |bc_s;

  // request matrix: req_s[output][input]
  always_comb begin
    for (int o = 0; o < num_ntrfs; o++) begin
      for (int i = 0; i < num_ntrfs; i++) begin
        req_s[o][i] = uni_s[i] && (tgt_s[i] == 3'(o));
      end
    end
  end

  // arbitration and crossbar; a broadcast cycle suppresses every unicast grant
  always_comb begin
    popin_s = drop_s;
    push_s  = '0;
    ugnt_s  = '0;
    bpick_s = rr_pick(bc_s, bptr_r);
    bc_ok_s = 1'b1;
    for (int o = 0; o < num_ntrfs; o++) begin
      if ((3'(o) != bpick_s[2:0]) && full_s[o]) bc_ok_s = 1'b0;
      else                                       bc_ok_s = bc_ok_s;
    end
    bc_go_s = bc_cycle_s && bpick_s[3] && bc_ok_s;
    for (int o = 0; o < num_ntrfs; o++) begin
      pick_s[o] = rr_pick(req_s[o], rr_r[o]);
      din_s[o]  = data_out_i_in[pick_s[o][2:0]];
      if (bc_cycle_s) begin
        if (bc_go_s && (3'(o) != bpick_s[2:0])) begin
          push_s[o] = 1'b1;
          din_s[o]  = data_out_i_in[bpick_s[2:0]];
        end else begin
          push_s[o] = 1'b0;
        end
      end else if (pick_s[o][3] && !full_s[o]) begin
        ugnt_s[o]                = 1'b1;
        push_s[o]                = 1'b1;
        popin_s[pick_s[o][2:0]]  = 1'b1;
      end else begin
        push_s[o] = 1'b0;
      end
    end
    if (bc_go_s) popin_s[bpick_s[2:0]] = 1'b1;
    else         popin_s = popin_s;
  end

  // popin must collapse the moment reset asserts, independent of the clock
  assign popin = popin_s & {num_ntrfs{reset}};

  // saturating sum of this cycle's drops
  always_comb begin
    drop_sum_s = 3'd0;
    for (int i = 0; i < num_ntrfs; i++) begin
      drop_sum_s = drop_sum_s + 3'(drop_s[i]);
    end
    drop_add_s = {1'b0, drop_cnt_r} + 17'(drop_sum_s);
  end

  // arbiter pointers and drop counter
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      for (int o = 0; o < num_ntrfs; o++) rr_r[o] <= 3'd0;
      bptr_r     <= 3'd0;
      drop_cnt_r <= 16'd0;
    end else begin
      for (int o = 0; o < num_ntrfs; o++) begin
        if (ugnt_s[o]) rr_r[o] <= next_ptr(pick_s[o][2:0]);
        else           rr_r[o] <= rr_r[o];
      end
      if (bc_go_s) bptr_r <= next_ptr(bpick_s[2:0]);
      else         bptr_r <= bptr_r;
      drop_cnt_r <= drop_add_s[16] ? 16'hFFFF : drop_add_s[15:0];
    end
  end

  assign drop_cnt = drop_cnt_r;

  for (genvar o = 0; o < num_ntrfs; o++) begin : g_port
    mesh_out_fifo #(
      .pckg_sz   (pckg_sz),
      .fifo_depth(fifo_depth)
    ) u_fifo (
      .clk_i(clk_i),
      .reset(reset),
      .push (push_s[o]),
      .pop  (pop[o]),
      .din  (din_s[o]),
      .dout (data_out[o]),
      .full (full_s[o]),
      .empty(empty_s[o])
    );
    assign pndng[o] = !empty_s[o];
  end

endmodule
